// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx serializer among NReq byte producers. Requesters are chosen
// round-robin. A granted requester keeps the transmitter (packet lock) until it sends
// a byte flagged last or has sent MaxBurst consecutive bytes. A watchdog aborts a frame
// whose done pulse never arrives.
//
// Ports
//   clk_i           system clock
//   rst_ni          synchronous active-low reset
//   req_valid_i     per-requester byte valid
//   req_data_i      per-requester byte, requester i on bits [8i+7:8i]
//   req_last_i      per-requester end-of-packet flag, qualified by valid
//   req_ready_o     one-hot or zero; byte i accepted when valid[i] & ready[i]
//   grant_id_o      index of the current/last granted requester
//   busy_o          high while a byte is being started or sent
//   tx_start_o      one-cycle pulse to uart_tx: load tx_din_o and begin a frame
//   tx_din_o        byte for uart_tx, stable from start until the next accept
//   tx_done_tick_i  one-cycle pulse from uart_tx when the stop bit completes
//   timeout_err_o   one-cycle pulse when the watchdog aborts a frame
module uart_tx_arbiter #(
    parameter int unsigned NReq     = 4,
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned Timeout  = 200000,
    localparam int unsigned IdxW    = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NReq-1:0]     req_valid_i,
    input  logic [8*NReq-1:0]   req_data_i,
    input  logic [NReq-1:0]     req_last_i,
    output logic [NReq-1:0]     req_ready_o,
    output logic [IdxW-1:0]     grant_id_o,
    output logic                busy_o,
    output logic                tx_start_o,
    output logic [7:0]          tx_din_o,
    input  logic                tx_done_tick_i,
    output logic                timeout_err_o
);

    localparam int unsigned BurstW = $clog2(MaxBurst + 1);
    localparam int unsigned WdogW  = (Timeout > 1) ? $clog2(Timeout) : 1;

    typedef enum logic [1:0] {
        StArb,
        StStart,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IdxW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic              last_q, last_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;

    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;
    logic [IdxW-1:0]   rr_cand;
    logic              lock_hit;
    logic [IdxW-1:0]   sel_idx;
    logic              accept;
    logic              wdog_at_max;
    logic [IdxW-1:0]   next_ptr;

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NReq.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        rr_cand  = '0;
        for (int unsigned k = 0; k < NReq; k++) begin
            rr_cand = IdxW'((32'(rr_ptr_q) + k) % NReq);
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // The lock only holds while the locked requester is still offering a byte; otherwise
    // plain round-robin takes over in the same cycle.
    assign lock_hit    = lock_q && req_valid_i[grant_id_q];
    assign sel_idx     = lock_hit ? grant_id_q : rr_idx;
    assign accept      = (state_q == StArb) && rst_ni && (lock_hit || rr_found);
    assign wdog_at_max = (wdog_q == WdogW'(Timeout - 1));
    assign next_ptr    = (grant_id_q == IdxW'(NReq - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        burst_cnt_d = burst_cnt_q;
        grant_id_d  = grant_id_q;
        tx_din_d    = tx_din_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        unique case (state_q)
            StArb: begin
                if (lock_q && !lock_hit) begin
                    lock_d = 1'b0;
                end
                if (accept) begin
                    tx_din_d    = req_data_i[{sel_idx, 3'b000} +: 8];
                    grant_id_d  = sel_idx;
                    last_d      = req_last_i[sel_idx];
                    burst_cnt_d = lock_hit ? burst_cnt_q + 1'b1 : BurstW'(1);
                    state_d     = StStart;
                end
            end
            StStart: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                // Done beats a coincident watchdog expiry.
                if (tx_done_tick_i) begin
                    state_d = StArb;
                    if (last_q || (burst_cnt_q == BurstW'(MaxBurst))) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                    end else begin
                        lock_d = 1'b1;
                    end
                end else if (wdog_at_max) begin
                    state_d  = StArb;
                    lock_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StArb;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            burst_cnt_q <= '0;
            grant_id_q  <= '0;
            tx_din_q    <= '0;
            last_q      <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            burst_cnt_q <= burst_cnt_d;
            grant_id_q  <= grant_id_d;
            tx_din_q    <= tx_din_d;
            last_q      <= last_d;
            wdog_q      <= wdog_d;
        end
    end

    assign grant_id_o    = grant_id_q;
    assign tx_din_o      = tx_din_q;
    assign busy_o        = (state_q == StStart) || (state_q == StWait);
    assign tx_start_o    = (state_q == StStart);
    assign timeout_err_o = rst_ni && (state_q == StWait) && wdog_at_max && !tx_done_tick_i;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NReq = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            tx_start;
    logic [7:0]      tx_din;
    logic            tx_done_tick;
    logic            timeout_err;

    uart_tx_arbiter #(
        .NReq     (4),
        .MaxBurst (4),
        .Timeout  (50)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .grant_id_o     (grant_id),
        .busy_o         (busy),
        .tx_start_o     (tx_start),
        .tx_din_o       (tx_din),
        .tx_done_tick_i (tx_done_tick),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [NReq][$];   // per-requester {last, data}
    logic [9:0] exp_q [$];      // expected {grant, data} per tx_start
    int         exp_to [$];     // expected cycles from tx_start to timeout_err
    logic       rst_mode;
    logic       done_en;
    int         done_dly;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && exp_to.size() == 0 && !busy &&
                rq[0].size() == 0 && rq[1].size() == 0 &&
                rq[2].size() == 0 && rq[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk_i);
    endtask

    // Requester driver: pops a byte after the edge that accepted it.
    initial begin
        logic [3:0] hs;
        logic [8:0] head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            if (rst_mode) begin
                req_valid = 4'hF;
                req_data  = '0;
                req_last  = 4'hF;
            end else begin
                for (int i = 0; i < NReq; i++) begin
                    if (rq[i].size() > 0) begin
                        head = rq[i][0];
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = head[7:0];
                        req_last[i]        = head[8];
                    end else begin
                        req_valid[i] = 1'b0;
                        req_last[i]  = 1'b0;
                    end
                end
            end
            @(negedge clk_i);
            hs = req_valid & req_ready;
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NReq; i++) begin
                if (hs[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                end
            end
        end
    end

    // uart_tx stand-in: done pulse done_dly cycles after each tx_start.
    initial begin
        int pend;
        pend = 0;
        tx_done_tick = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            tx_done_tick = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done_tick = 1'b1;
            end
            if (tx_start && done_en) pend = done_dly;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       acc_prev;
        int         since;
        logic [9:0] e;
        logic [7:0] last_din;
        int         et;
        acc_prev = 1'b0;
        since    = 0;
        last_din = '0;
        forever begin
            @(negedge clk_i);
            if (tx_start) begin
                chk("start_after_accept", {31'd0, acc_prev}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", {24'd0, tx_din}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", {30'd0, grant_id}, {30'd0, e[9:8]});
                    chk("data", {24'd0, tx_din}, {24'd0, e[7:0]});
                end
                last_din = tx_din;
                since = 0;
            end else begin
                since++;
            end
            if (tx_done_tick && busy) begin
                chk("din_hold", {24'd0, tx_din}, {24'd0, last_din});
            end
            if (timeout_err) begin
                if (exp_to.size() == 0) begin
                    chk("unexpected_timeout", since, 32'hFFFF_FFFF);
                end else begin
                    et = exp_to.pop_front();
                    chk("timeout_delay", since, et);
                end
            end
            acc_prev = |(req_valid & req_ready);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic ok;
        rst_ni   = 1'b0;
        rst_mode = 1'b1;
        done_en  = 1'b1;
        done_dly = 20;

        // Reset with every requester valid.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_din", {24'd0, tx_din}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_mode = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Round robin, every byte last.
        for (int i = 0; i < NReq; i++) push_req(i, 8'hA0 + 8'(i), 1'b1);
        push_req(0, 8'hA0, 1'b1);
        expect_byte(2'd0, 8'hA0);
        expect_byte(2'd1, 8'hA1);
        expect_byte(2'd2, 8'hA2);
        expect_byte(2'd3, 8'hA3);
        expect_byte(2'd0, 8'hA0);
        wait_idle(400, "rr_idle");

        // Packet lock: rr_ptr is 1; req1 packet of three, req2 waits.
        push_req(1, 8'hB1, 1'b0);
        push_req(1, 8'hB2, 1'b0);
        push_req(1, 8'hB3, 1'b1);
        push_req(2, 8'hC1, 1'b1);
        expect_byte(2'd1, 8'hB1);
        expect_byte(2'd1, 8'hB2);
        expect_byte(2'd1, 8'hB3);
        expect_byte(2'd2, 8'hC1);
        wait_idle(400, "lock_idle");

        // Burst limit: rr_ptr is 3; req1 never last, released after the 4th byte.
        for (int i = 1; i <= 5; i++) push_req(1, 8'hD0 + 8'(i), 1'b0);
        push_req(2, 8'hE1, 1'b1);
        expect_byte(2'd1, 8'hD1);
        expect_byte(2'd1, 8'hD2);
        expect_byte(2'd1, 8'hD3);
        expect_byte(2'd1, 8'hD4);
        expect_byte(2'd2, 8'hE1);
        expect_byte(2'd1, 8'hD5);
        wait_idle(600, "burst_idle");

        // Lock drop: req0 locked then goes invalid; rr_ptr still 3 so req3 first.
        push_req(0, 8'hF0, 1'b0);
        expect_byte(2'd0, 8'hF0);
        repeat (5) @(negedge clk_i);
        push_req(3, 8'h93, 1'b1);
        push_req(1, 8'h91, 1'b1);
        expect_byte(2'd3, 8'h93);
        expect_byte(2'd1, 8'h91);
        wait_idle(400, "drop_idle");

        // Timeout on a non-last byte: lock cleared, next grant goes to req3.
        done_en = 1'b0;
        push_req(2, 8'h52, 1'b0);
        push_req(2, 8'h53, 1'b1);
        push_req(3, 8'h54, 1'b1);
        expect_byte(2'd2, 8'h52);
        exp_to.push_back(50);
        expect_byte(2'd3, 8'h54);
        expect_byte(2'd2, 8'h53);
        repeat (10) @(negedge clk_i);
        done_en = 1'b1;
        wait_idle(600, "timeout_idle");

        // Done on the last watchdog cycle wins: no error pulse.
        done_dly = 50;
        push_req(3, 8'h55, 1'b1);
        expect_byte(2'd3, 8'h55);
        wait_idle(200, "coincide_idle");
        done_dly = 20;

        // Reset in WAIT while req1 is locked and rr_ptr is 1.
        push_req(0, 8'h60, 1'b1);
        expect_byte(2'd0, 8'h60);
        wait_idle(200, "pre_rst_idle");
        push_req(1, 8'h61, 1'b0);
        push_req(1, 8'h62, 1'b0);
        expect_byte(2'd1, 8'h61);
        expect_byte(2'd1, 8'h62);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_wait_started", {31'd0, ok}, 32'd1);
        repeat (5) @(negedge clk_i);
        chk("rst_wait_busy_before", {31'd0, busy}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rst_wait_busy_after", {31'd0, busy}, 32'd0);
        chk("rst_wait_grant", {30'd0, grant_id}, 32'd0);
        repeat (25) @(negedge clk_i);
        chk("late_done_ignored", {31'd0, busy}, 32'd0);
        push_req(1, 8'h71, 1'b1);
        push_req(0, 8'h70, 1'b1);
        push_req(3, 8'h73, 1'b1);
        expect_byte(2'd0, 8'h70);
        expect_byte(2'd1, 8'h71);
        expect_byte(2'd3, 8'h73);
        wait_idle(400, "post_rst_idle");

        chk("exp_left", exp_q.size(), 32'd0);
        chk("exp_to_left", exp_to.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
